// File: rtl/fdct4_serial.sv
// 4-point forward integer DCT (HEVC 64/83/36) with serial sample input and parallel coefficient output.
// Latency: out_valid rises 3 clk edges after the edge that accepts x3, giving a minimum block period of 8 cycles.
// Backpressure: in_ready is low from BFLY until the result is taken; OUT holds the result until out_ready.
module fdct4_serial #(
   parameter int IN_W  = 25,
   parameter int OUT_W = 25,
   parameter int SHIFT = 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_c0,
   output logic signed [OUT_W-1:0] out_c1,
   output logic signed [OUT_W-1:0] out_c2,
   output logic signed [OUT_W-1:0] out_c3
);

   // Butterfly terms need one extra bit; products need 8 more (83 < 2^7, plus a sum).
   localparam int EW = IN_W + 1;
   localparam int SW = IN_W + 9;
   localparam int RW = SW + 1;

   localparam logic signed [SW-1:0] K64 = SW'(64);
   localparam logic signed [SW-1:0] K83 = SW'(83);
   localparam logic signed [SW-1:0] K36 = SW'(36);

   localparam logic signed [RW-1:0] ADD  = RW'(longint'(1) << (SHIFT - 1));
   localparam logic signed [RW-1:0] MAXV = RW'((longint'(1) << (OUT_W - 1)) - 1);
   localparam logic signed [RW-1:0] MINV = RW'(-(longint'(1) << (OUT_W - 1)));

   typedef enum logic [2:0] {FILL, BFLY, MAC, RND, OUT} state_t;

   state_t                  r_state;
   logic [1:0]              r_idx;
   logic signed [IN_W-1:0]  r_x [4];
   logic signed [EW-1:0]    r_e0, r_e1, r_o0, r_o1;
   logic signed [SW-1:0]    r_s0, r_s1, r_s2, r_s3;

   logic signed [SW-1:0]    w_e0x, w_e1x, w_o0x, w_o1x;
   logic signed [SW-1:0]    w_s0, w_s1, w_s2, w_s3;

   // Round half up, floor the shift, then clamp into the output range.
   function automatic logic signed [OUT_W-1:0] rnd_sat(input logic signed [SW-1:0] s);
      logic signed [RW-1:0] t;
      t = (RW'(s) + ADD) >>> SHIFT;
      if (t > MAXV)
         rnd_sat = MAXV[OUT_W-1:0];
      else if (t < MINV)
         rnd_sat = MINV[OUT_W-1:0];
      else
         rnd_sat = t[OUT_W-1:0];
   endfunction

   assign in_ready = (r_state == FILL);

   // Multiply stage operands, sign-extended to full product precision.
   assign w_e0x = SW'(r_e0);
   assign w_e1x = SW'(r_e1);
   assign w_o0x = SW'(r_o0);
   assign w_o1x = SW'(r_o1);
   assign w_s0  = (w_e0x + w_e1x) * K64;
   assign w_s2  = (w_e0x - w_e1x) * K64;
   assign w_s1  = (w_o0x * K83) + (w_o1x * K36);
   assign w_s3  = (w_o0x * K36) - (w_o1x * K83);

   // Block sequencer: collect four samples, then butterfly, multiply, round, and hand off.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= FILL;
         r_idx     <= 2'd0;
         for (int i = 0; i < 4; i++) r_x[i] <= '0;
         r_e0      <= '0;
         r_e1      <= '0;
         r_o0      <= '0;
         r_o1      <= '0;
         r_s0      <= '0;
         r_s1      <= '0;
         r_s2      <= '0;
         r_s3      <= '0;
         out_valid <= 1'b0;
         out_c0    <= '0;
         out_c1    <= '0;
         out_c2    <= '0;
         out_c3    <= '0;
      end else begin
         case (r_state)
            FILL: begin
               if (in_valid) begin
                  r_x[r_idx] <= in_data;
                  if (r_idx == 2'd3) begin
                     r_idx   <= 2'd0;
                     r_state <= BFLY;
                  end else begin
                     r_idx <= r_idx + 2'd1;
                  end
               end
            end
            BFLY: begin
               r_e0    <= EW'(r_x[0]) + EW'(r_x[3]);
               r_e1    <= EW'(r_x[1]) + EW'(r_x[2]);
               r_o0    <= EW'(r_x[0]) - EW'(r_x[3]);
               r_o1    <= EW'(r_x[1]) - EW'(r_x[2]);
               r_state <= MAC;
            end
            MAC: begin
               r_s0    <= w_s0;
               r_s1    <= w_s1;
               r_s2    <= w_s2;
               r_s3    <= w_s3;
               r_state <= RND;
            end
            RND: begin
               out_c0    <= rnd_sat(r_s0);
               out_c1    <= rnd_sat(r_s1);
               out_c2    <= rnd_sat(r_s2);
               out_c3    <= rnd_sat(r_s3);
               out_valid <= 1'b1;
               r_state   <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= FILL;
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

endmodule
